// File: rtl/control_contador_pkg.sv
// Shared encodings for the cascaded-counter command sequencer.
package control_contador_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  localparam logic [1:0] MODO_UP    = 2'b00;
  localparam logic [1:0] MODO_DOWN  = 2'b01;
  localparam logic [1:0] MODO_DOWN3 = 2'b10;
  localparam logic [1:0] MODO_LOAD  = 2'b11;

  typedef enum logic [1:0] {
    StIdle  = ST_IDLE,
    StLoad  = ST_LOAD,
    StRun   = ST_RUN,
    StDrain = ST_DRAIN
  } state_e;

endpackage

// File: rtl/contador_sat.sv
// Saturating up-counter with synchronous clear (clear wins over enable).
module contador_sat #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [Width-1:0] cnt_o
);

  logic [Width-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + Width'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/control_contador.sv
// Command sequencer: one parallel-load cycle, CMD_LEN counting cycles, one drain
// cycle, then a DONE pulse with the captured Q and RCO tally.
module control_contador
  import control_contador_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned LEN_W = 8,
  parameter int unsigned CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CMD_VALID,
  output logic             CMD_READY,
  input  logic [1:0]       CMD_MODO,
  input  logic [WIDTH-1:0] CMD_DATA,
  input  logic [LEN_W-1:0] CMD_LEN,
  input  logic [WIDTH-1:0] Q_IN,
  input  logic             RCO_IN,
  output logic [1:0]       MODO,
  output logic [WIDTH-1:0] D,
  output logic             ENB,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] Q_LAST,
  output logic [CNT_W-1:0] RCO_CNT
);

  state_e           state_d, state_q;
  logic [1:0]       mode_d, mode_q;
  logic [LEN_W-1:0] rem_d, rem_q;
  logic [1:0]       modo_d, modo_q;
  logic [WIDTH-1:0] d_d, d_q;
  logic             enb_d, enb_q;
  logic             done_d, done_q;
  logic [WIDTH-1:0] q_last_d, q_last_q;
  logic             accept;
  logic             rco_en;

  assign CMD_READY = (state_q == StIdle) && !RST;
  assign accept    = CMD_VALID && CMD_READY;
  assign rco_en    = RCO_IN && ((state_q == StRun) || (state_q == StDrain));

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    rem_d    = rem_q;
    modo_d   = modo_q;
    d_d      = d_q;
    enb_d    = enb_q;
    done_d   = 1'b0;
    q_last_d = q_last_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          mode_d  = CMD_MODO;
          rem_d   = CMD_LEN;
          d_d     = CMD_DATA;
          modo_d  = MODO_LOAD;
          enb_d   = 1'b1;
          state_d = StLoad;
        end
      end
      StLoad: begin
        if (rem_q == '0) begin
          enb_d   = 1'b0;
          state_d = StDrain;
        end else begin
          modo_d  = mode_q;
          enb_d   = 1'b1;
          state_d = StRun;
        end
      end
      StRun: begin
        rem_d = rem_q - LEN_W'(1);
        if (rem_q == LEN_W'(1)) begin
          enb_d   = 1'b0;
          state_d = StDrain;
        end
      end
      StDrain: begin
        // Counter Q has settled: its last enabled update landed on the previous edge.
        q_last_d = Q_IN;
        done_d   = 1'b1;
        modo_d   = MODO_UP;
        enb_d    = 1'b0;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= StIdle;
      mode_q   <= MODO_UP;
      rem_q    <= '0;
      modo_q   <= MODO_UP;
      d_q      <= '0;
      enb_q    <= 1'b0;
      done_q   <= 1'b0;
      q_last_q <= '0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      rem_q    <= rem_d;
      modo_q   <= modo_d;
      d_q      <= d_d;
      enb_q    <= enb_d;
      done_q   <= done_d;
      q_last_q <= q_last_d;
    end
  end

  contador_sat #(
    .Width(CNT_W)
  ) u_rco_cnt (
    .clk_i(CLK),
    .rst_i(RST),
    .clr_i(accept),
    .en_i (rco_en),
    .cnt_o(RCO_CNT)
  );

  assign MODO   = modo_q;
  assign D      = d_q;
  assign ENB    = enb_q;
  assign BUSY   = (state_q != StIdle);
  assign DONE   = done_q;
  assign Q_LAST = q_last_q;

endmodule

// File: tb/tb_control_contador.sv
// Directed bench for control_contador driving a behavioural 16-bit counter model.
module tb_control_contador;

  logic        CLK = 1'b0;
  logic        RST;
  logic        CMD_VALID;
  logic        CMD_READY;
  logic [1:0]  CMD_MODO;
  logic [15:0] CMD_DATA;
  logic [7:0]  CMD_LEN;
  logic [15:0] Q_IN;
  logic        RCO_IN;
  logic [1:0]  MODO;
  logic [15:0] D;
  logic        ENB;
  logic        BUSY;
  logic        DONE;
  logic [15:0] Q_LAST;
  logic [7:0]  RCO_CNT;

  int vectors = 0;
  int errors  = 0;
  int enb_cnt = 0;
  int done_cnt = 0;
  int dbl_done = 0;
  logic done_prev = 1'b0;
  logic [15:0] q_hist[$];
  int lat;
  int done_base;

  always #5 CLK = ~CLK;

  control_contador #(
    .WIDTH(16),
    .LEN_W(8),
    .CNT_W(8)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .CMD_VALID(CMD_VALID),
    .CMD_READY(CMD_READY),
    .CMD_MODO (CMD_MODO),
    .CMD_DATA (CMD_DATA),
    .CMD_LEN  (CMD_LEN),
    .Q_IN     (Q_IN),
    .RCO_IN   (RCO_IN),
    .MODO     (MODO),
    .D        (D),
    .ENB      (ENB),
    .BUSY     (BUSY),
    .DONE     (DONE),
    .Q_LAST   (Q_LAST),
    .RCO_CNT  (RCO_CNT)
  );

  // Counter model: registered Q and RCO; RCO flags a wrap on the enabled edge.
  logic [15:0] cq;
  logic        crco;
  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      cq   <= 16'h0000;
      crco <= 1'b0;
    end else if (ENB) begin
      case (MODO)
        2'b00:   begin cq <= cq + 16'd1; crco <= (cq == 16'hFFFF); end
        2'b01:   begin cq <= cq - 16'd1; crco <= (cq == 16'h0000); end
        2'b10:   begin cq <= cq - 16'd3; crco <= (cq < 16'd3);     end
        default: begin cq <= D;          crco <= 1'b0;            end
      endcase
    end else begin
      crco <= 1'b0;
    end
  end
  assign Q_IN   = cq;
  assign RCO_IN = crco;

  always @(posedge CLK) begin
    if (ENB) enb_cnt <= enb_cnt + 1;
    if (DONE) done_cnt <= done_cnt + 1;
    if (DONE && done_prev) dbl_done <= dbl_done + 1;
    done_prev <= DONE;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic start_cmd(input logic [15:0] data, input logic [1:0] modo, input logic [7:0] len);
    CMD_DATA  = data;
    CMD_MODO  = modo;
    CMD_LEN   = len;
    CMD_VALID = 1'b1;
    check("ready_before_accept", CMD_READY, 1);
    enb_cnt = 0;
    q_hist.delete();
    @(posedge CLK);
    #1;
    CMD_VALID = 1'b0;
    check("load_enb", ENB, 1);
    check("load_modo", MODO, 2'b11);
    check("load_d", D, data);
    check("load_busy", BUSY, 1);
    check("rco_cleared_on_accept", RCO_CNT, 0);
  endtask

  task automatic wait_done(output int latency);
    latency = 0;
    for (int i = 0; i < 300; i++) begin
      @(posedge CLK);
      #1;
      latency++;
      q_hist.push_back(Q_IN);
      if (DONE) break;
    end
    if (!DONE) check("done_timeout", 0, 1);
  endtask

  initial begin
    RST       = 1'b1;
    CMD_VALID = 1'b0;
    CMD_MODO  = 2'b00;
    CMD_DATA  = 16'h0000;
    CMD_LEN   = 8'd0;
    step(2);
    check("rst_ready", CMD_READY, 0);
    check("rst_busy", BUSY, 0);
    check("rst_enb", ENB, 0);
    check("rst_modo", MODO, 0);
    check("rst_d", D, 0);
    check("rst_done", DONE, 0);
    check("rst_qlast", Q_LAST, 0);
    check("rst_rcocnt", RCO_CNT, 0);
    RST = 1'b0;
    #1;
    check("ready_after_rst", CMD_READY, 1);
    step(1);

    // Up from FFFE for 3 cycles wraps once.
    start_cmd(16'hFFFE, 2'b00, 8'd3);
    wait_done(lat);
    check("t1_latency", lat, 5);
    check("t1_q1", q_hist[1], 16'hFFFF);
    check("t1_q2", q_hist[2], 16'h0000);
    check("t1_q3", q_hist[3], 16'h0001);
    check("t1_qlast", Q_LAST, 16'h0001);
    check("t1_rcocnt", RCO_CNT, 1);
    check("t1_enb_cycles", enb_cnt, 4);
    check("t1_modo_idle", MODO, 0);
    check("t1_busy_done", BUSY, 0);

    // Issued in the DONE cycle: down from 0002 for 4 cycles.
    start_cmd(16'h0002, 2'b01, 8'd4);
    wait_done(lat);
    check("t2_latency", lat, 6);
    check("t2_qlast", Q_LAST, 16'hFFFE);
    check("t2_rcocnt", RCO_CNT, 1);

    start_cmd(16'h0009, 2'b10, 8'd3);
    wait_done(lat);
    check("t3_latency", lat, 5);
    check("t3_qlast", Q_LAST, 16'h0000);
    check("t3_rcocnt", RCO_CNT, 0);
    check("t3_enb_cycles", enb_cnt, 4);

    start_cmd(16'h1234, 2'b00, 8'd0);
    wait_done(lat);
    check("t4_latency", lat, 2);
    check("t4_qlast", Q_LAST, 16'h1234);
    check("t4_rcocnt", RCO_CNT, 0);
    check("t4_enb_cycles", enb_cnt, 1);
    step(2);
    check("t4_done_low", DONE, 0);
    check("t4_qlast_hold", Q_LAST, 16'h1234);

    // Mode 11 run keeps reloading D.
    start_cmd(16'hBEEF, 2'b11, 8'd2);
    wait_done(lat);
    check("t5_latency", lat, 4);
    check("t5_qlast", Q_LAST, 16'hBEEF);
    step(1);

    // A command pulse while busy must be dropped.
    done_base = done_cnt;
    start_cmd(16'h0100, 2'b00, 8'd5);
    step(2);
    CMD_DATA  = 16'hAAAA;
    CMD_LEN   = 8'd0;
    CMD_VALID = 1'b1;
    check("t6_ready_busy", CMD_READY, 0);
    step(1);
    CMD_VALID = 1'b0;
    wait_done(lat);
    check("t6_qlast", Q_LAST, 16'h0105);
    step(4);
    check("t6_done_count", done_cnt - done_base, 1);
    check("t6_busy_after", BUSY, 0);

    // Asynchronous reset mid-run.
    start_cmd(16'h0000, 2'b00, 8'd10);
    step(3);
    check("t7_running", ENB, 1);
    done_base = done_cnt;
    #3;
    RST = 1'b1;
    #1;
    check("t7_rst_enb", ENB, 0);
    check("t7_rst_modo", MODO, 0);
    check("t7_rst_busy", BUSY, 0);
    check("t7_rst_ready", CMD_READY, 0);
    check("t7_rst_qlast", Q_LAST, 0);
    step(1);
    RST = 1'b0;
    #1;
    check("t7_ready_release", CMD_READY, 1);
    step(12);
    check("t7_no_done", done_cnt - done_base, 0);
    check("t7_busy_idle", BUSY, 0);

    check("done_never_double", dbl_done, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/control_contador.md
# control_contador

Upstream command sequencer for the 16-bit cascaded counter. It accepts one command at a time over a valid/ready handshake: preload value, counting mode and cycle count. It then drives the counter's MODO, D and ENB inputs: one parallel-load cycle, then N enabled counting cycles. Afterwards it captures the counter's final Q and the number of RCO pulses seen, and reports completion with a one-cycle DONE pulse.

## Interface
- WIDTH, 16: counter data width, matches the cascaded counter.
- LEN_W, 8: width of the run-length field.
- CNT_W, 8: width of the RCO pulse tally.
- CLK  in  1  single clock; all state updates on the rising edge.
- RST  in  1  reset, asynchronous and active-high.
- CMD_VALID  in  1  command present.
- CMD_READY  out  1  block can accept a command; combinational, high only in IDLE and while RST low.
- CMD_MODO  in  2  counting mode for the run phase (00 up, 01 down, 10 down-by-3, 11 load).
- CMD_DATA  in  WIDTH  preload value.
- CMD_LEN  in  LEN_W  number of enabled counting cycles (0 allowed).
- Q_IN  in  WIDTH  counter output Q.
- RCO_IN  in  1  counter ripple-carry output (registered in the counter).
- MODO  out  2  to counter MODO, registered.
- D  out  WIDTH  to counter D, registered.
- ENB  out  1  to counter ENB, registered.
- BUSY  out  1  high in any state other than IDLE.
- DONE  out  1  one-cycle pulse; Q_LAST and RCO_CNT are valid in this cycle.
- Q_LAST  out  WIDTH  counter Q captured at end of command.
- RCO_CNT  out  CNT_W  RCO_IN high cycles counted during RUN and DRAIN, saturating.

## Operation
- Reset values:
  - state IDLE.
  - MODO=00, D=0, ENB=0.
  - DONE=0, BUSY=0.
  - Q_LAST=0, RCO_CNT=0.
  - CMD_READY=0 while RST is high.
- FSM states: IDLE, LOAD, RUN, DRAIN.
- IDLE:
  - Accept when CMD_VALID&&CMD_READY at an edge.
  - Latch CMD_MODO and CMD_LEN into the remaining-cycles counter; drive D<=CMD_DATA, MODO<=11, ENB<=1.
  - Clear RCO_CNT, then go to LOAD.
- LOAD, exactly one cycle:
  - If len==0, go to DRAIN with ENB<=0.
  - Otherwise MODO<=latched mode, ENB<=1, go to RUN.
- RUN:
  - ENB held 1; the remaining counter decrements each cycle.
  - When remaining==1, ENB<=0 and go to DRAIN.
  - Result: exactly CMD_LEN enabled cycles in the run mode.
- DRAIN, one cycle, ENB=0: absorbs the counter's one-cycle register latency. At the edge:
  - Q_LAST<=Q_IN.
  - DONE<=1.
  - MODO<=00.
  - State returns to IDLE.
- RCO_CNT increments by 1 on every RUN or DRAIN cycle with RCO_IN=1, and saturates at 2^CNT_W-1.
- CMD_MODO=11 is legal: the run phase reloads D every cycle, so Q_LAST=CMD_DATA.
- CMD_VALID while BUSY is ignored, with no queuing. CMD_* must be held until accepted.
- Async RST mid-command returns all outputs to reset values immediately. The in-flight command is lost and no DONE is produced.

## Timing
- Accept edge t0: LOAD occupies t0..t1 with ENB=1 and MODO=11 visible.
- RUN occupies CMD_LEN cycles. DRAIN is 1 cycle. DONE is high in the first IDLE cycle.
- Accept-to-DONE latency is CMD_LEN+2 cycles (2 when LEN=0).
- Back-to-back commands: CMD_READY is high in the DONE cycle, so a new accept is allowed there. That gives a throughput of one command per CMD_LEN+2 cycles.
- DONE is never high for 2 consecutive cycles.
- Q_LAST and RCO_CNT hold until the next accept; RCO_CNT clears on the accept edge.

## Structure
- Shared package holds:
  - state encoding localparams ST_IDLE, ST_LOAD, ST_RUN, ST_DRAIN.
  - mode constants MODO_UP=00, MODO_DOWN=01, MODO_DOWN3=10, MODO_LOAD=11.
- Sub-module: contador_sat, a parameterised saturating incrementer with clear and enable, used for RCO_CNT.
- The remaining-cycles down-counter stays inline.

## Test plan
The bench uses a behavioural 16-bit counter model (registered Q and RCO, same mode semantics).

- Load 0xFFFE, mode 00, LEN=3 → Q sequence FFFF, 0000, 0001; Q_LAST=0x0001, RCO_CNT=1, DONE 5 cycles after accept.
- Load 0x0002, mode 01, LEN=4 → Q_LAST=0xFFFE, RCO_CNT=1 (Q=0000 pass).
- Load 0x0009, mode 10, LEN=3 → Q_LAST=0x0000, ENB high for exactly 4 cycles including LOAD.
- LEN=0, mode 00, load 0x1234 → Q_LAST=0x1234, RCO_CNT=0, DONE 2 cycles after accept.
- Second command presented in the DONE cycle → accepted immediately. A CMD_VALID pulse while BUSY → ignored, no extra DONE.
- RST asserted during RUN (LEN=10, cycle 4) → ENB=0, MODO=00, BUSY=0 asynchronously. No DONE. CMD_READY=1 after release.
